// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// States, BCD digit limits and the 00-59 lower-field range.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  localparam int unsigned LOW_MAX =
    10 * int'(BCD_FIVE) + int'(BCD_NINE);

endpackage

// File: rtl/bcd_field_counter.sv
// One two-digit BCD field, 00..MAX, with wrap-around
// increment and a borrow-chained decrement.
module bcd_field_counter
  import timer_pkg::*;
#(
  parameter int unsigned MAX = LOW_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  input  logic       borrow_in,
  output logic [7:0] value,
  output logic       is_zero,
  output logic       borrow_out
);

  localparam logic [3:0] MAX_T = 4'(MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MAX % 10);

  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       w_at_max;

  assign value      = {r_tens, r_ones};
  assign is_zero    = (r_tens == 4'd0) && (r_ones == 4'd0);
  assign borrow_out = borrow_in && is_zero;
  assign w_at_max   = (r_tens == MAX_T) && (r_ones == MAX_O);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (load) begin
      r_tens <= load_val[7:4];
      r_ones <= load_val[3:0];
    end else if (dec && borrow_in) begin
      if (is_zero) begin
        r_tens <= MAX_T;
        r_ones <= MAX_O;
      end else if (r_ones == 4'd0) begin
        r_ones <= BCD_NINE;
        r_tens <= r_tens - 4'd1;
      end else begin
        r_ones <= r_ones - 4'd1;
      end
    end else if (inc) begin
      if (w_at_max) begin
        r_tens <= 4'd0;
        r_ones <= 4'd0;
      end else if (r_ones == BCD_NINE) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer_core.sv
// N-field BCD countdown timer: prescaler, run/pause/expire FSM.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry.
module countdown_timer_core
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned N_FIELDS = 2,
  parameter int unsigned TOP_MAX  = 59
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     inc,
  input  logic [$clog2((N_FIELDS > 1) ? N_FIELDS : 2)-1:0] inc_sel,
  output logic [8*N_FIELDS-1:0]    digits,
  output logic [1:0]               state,
  output logic                     running,
  output logic                     expired,
  output logic                     alarm
);

  localparam int unsigned SW = $clog2((N_FIELDS > 1) ? N_FIELDS : 2);
  localparam int unsigned PW = $clog2(TICK_DIV);

  state_t r_state;
  state_t w_state_nxt;

  logic [PW-1:0] r_presc;
  logic          r_expired;
  logic          r_running;
  logic          r_alarm;

  logic w_tick;
  logic w_zero;
  logic w_one;
  logic w_clr;
  logic w_dec;
  logic w_inc_en;
  logic w_presc_clr;
  logic w_exp;
  logic w_load;
  logic w_borrow_top;

  logic [N_FIELDS-1:0]   w_is_zero;
  logic [N_FIELDS-1:0]   w_borrow;
  logic [8*N_FIELDS-1:0] w_digits;
  logic [8*N_FIELDS-1:0] w_load_val;

  assign w_tick = (r_state == ST_RUN) &&
                  (r_presc == PW'(TICK_DIV - 1));
  assign w_zero = w_borrow_top;
  assign w_one  = (w_digits[7:0] == 8'h01) &&
                  (&(w_is_zero | N_FIELDS'(1)));

  assign w_borrow[0] = 1'b1;

  for (genvar k = 0; k < N_FIELDS; k++) begin : g_field
    localparam int unsigned FMAX =
      (k == N_FIELDS - 1) ? TOP_MAX : LOW_MAX;
    logic w_bo;

    bcd_field_counter #(
      .MAX(FMAX)
    ) u_field (
      .clk       (clk),
      .reset     (reset),
      .clr       (w_clr),
      .load      (w_load),
      .load_val  (w_load_val[8*k +: 8]),
      .inc       (w_inc_en && (inc_sel == SW'(k))),
      .dec       (w_dec),
      .borrow_in (w_borrow[k]),
      .value     (w_digits[8*k +: 8]),
      .is_zero   (w_is_zero[k]),
      .borrow_out(w_bo)
    );

    if (k < N_FIELDS - 1) begin : g_chain
      assign w_borrow[k+1] = w_bo;
    end else begin : g_top
      assign w_borrow_top = w_bo;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [8*N_FIELDS-1:0] r_preset;
  logic                  w_latch;

  assign w_latch = (r_state == ST_IDLE) &&
                   (w_state_nxt == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset || w_clr) begin
      r_preset <= '0;
    end else if (w_latch) begin
      r_preset <= w_digits;
    end
  end

  assign w_load_val = r_preset;
`else
  assign w_load_val = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_dec       = 1'b0;
    w_inc_en    = 1'b0;
    w_presc_clr = 1'b0;
    w_exp       = 1'b0;
    w_load      = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_clr       = 1'b1;
      w_presc_clr = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (!w_zero) begin
              w_state_nxt = ST_RUN;
              w_presc_clr = 1'b1;
            end
          end else begin
            w_inc_en = inc;
          end
        end
        ST_RUN: begin
          if (start) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_tick) begin
            if (w_one) begin
              w_exp = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              w_load = 1'b1;
`else
              w_dec       = 1'b1;
              w_state_nxt = ST_EXPIRED;
`endif
            end else begin
              w_dec = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (start) begin
            w_state_nxt = w_zero ? ST_IDLE : ST_RUN;
            w_presc_clr = 1'b1;
          end else begin
            w_inc_en = inc;
          end
        end
        ST_EXPIRED: begin
          if (start) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Prescaler only advances while running; pause holds it.
  always_ff @(posedge clk) begin
    if (reset || w_presc_clr) begin
      r_presc <= '0;
    end else if (r_state == ST_RUN) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_expired <= 1'b0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_expired <= w_exp;
      r_running <= (w_state_nxt == ST_RUN);
      r_alarm   <= (w_state_nxt == ST_EXPIRED);
    end
  end

  assign digits  = w_digits;
  assign state   = r_state;
  assign running = r_running;
  assign expired = r_expired;
  assign alarm   = r_alarm;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Bench for countdown_timer_core: vector table, corner sequences
// and a random run against a value-level reference model.
module tb_countdown_timer_core;

  localparam int TD = 4;
  localparam int NF = 2;
  localparam int TM = 59;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          clear;
  logic          inc;
  logic [0:0]    inc_sel;
  logic [15:0]   digits;
  logic [1:0]    state;
  logic          running;
  logic          expired;
  logic          alarm;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  countdown_timer_core #(
    .TICK_DIV(TD),
    .N_FIELDS(NF),
    .TOP_MAX (TM)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .clear  (clear),
    .inc    (inc),
    .inc_sel(inc_sel),
    .digits (digits),
    .state  (state),
    .running(running),
    .expired(expired),
    .alarm  (alarm)
  );

  // Reference model: field values as integers, total in seconds-like units.
  int mf[NF];
  int mst;
  int mpre;
  int mexp;
  int mpreset;

  function automatic int m_total();
    int t = 0;
    int w = 1;
    for (int k = 0; k < NF; k++) begin
      t += mf[k] * w;
      w *= 60;
    end
    return t;
  endfunction

  function automatic void m_set(int t);
    for (int k = 0; k < NF - 1; k++) begin
      mf[k] = t % 60;
      t     = t / 60;
    end
    mf[NF-1] = t;
  endfunction

  function automatic logic [15:0] m_digits();
    logic [15:0] d = '0;
    for (int k = 0; k < NF; k++) begin
      d[8*k +: 4]   = 4'(mf[k] % 10);
      d[8*k+4 +: 4] = 4'(mf[k] / 10);
    end
    return d;
  endfunction

  function automatic void m_inc(int sel);
    int mx = (sel == NF - 1) ? TM : 59;
    if (sel < NF) mf[sel] = (mf[sel] + 1) % (mx + 1);
  endfunction

  function automatic void m_reset();
    m_set(0);
    mst = 0; mpre = 0; mexp = 0; mpreset = 0;
  endfunction

  function automatic void m_step(bit s, bit c, bit i, int sel);
    int t = m_total();
    mexp = 0;
    if (c) begin
      m_set(0); mst = 0; mpre = 0; mpreset = 0;
    end else begin
      case (mst)
        0: begin
          if (s) begin
            if (t != 0) begin
              mst = 1; mpre = 0; mpreset = t;
            end
          end else if (i) m_inc(sel);
        end
        1: begin
          if (s) mst = 2;
          else if (mpre == TD - 1) begin
            mpre = 0;
            m_set(t - 1);
            if (t == 1) begin
              mexp = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              m_set(mpreset);
`else
              mst = 3;
`endif
            end
          end else mpre++;
        end
        2: begin
          if (s) begin
            mst = (t != 0) ? 1 : 0; mpre = 0;
          end else if (i) m_inc(sel);
        end
        default: if (s) mst = 0;
      endcase
    end
  endfunction

  task automatic check(string nm, logic [15:0] ed, int es, bit ee);
    checks++;
    if (digits !== ed || state !== 2'(es) ||
        running !== (es == 1) || expired !== ee ||
        alarm !== (es == 3)) begin
      failures++;
      $display("FAIL %s: got digits=%h state=%0d run=%b exp=%b alarm=%b, want digits=%h state=%0d exp=%b",
               nm, digits, state, running, expired, alarm, ed, es, ee);
    end
  endtask

  task automatic cyc(bit s, bit c, bit i, int sel);
    start = s; clear = c; inc = i; inc_sel = 1'(sel);
    @(posedge clk);
    #1;
    m_step(s, c, i, sel);
    start = 0; clear = 0; inc = 0;
  endtask

  task automatic nops(int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    m_reset();
  endtask

  typedef struct {
    bit          s;
    bit          c;
    bit          i;
    int          sel;
    int          reps;
    logic [15:0] d;
    int          st;
    bit          ex;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 0; start = 0; clear = 0; inc = 0; inc_sel = '0;
    m_reset();

    tbl.push_back(vec_t'{0, 0, 1, 0, 1,  16'h0001, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 1,  16'h0002, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 1,  16'h0003, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 1,  16'h0103, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 1,  16'h0203, 0, 0});
    tbl.push_back(vec_t'{1, 0, 0, 0, 1,  16'h0203, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 3,  16'h0203, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1,  16'h0202, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 11, 16'h0200, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 1,  16'h0159, 1, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 1,  16'h0159, 1, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0, 1,  16'h0000, 0, 0});
    tbl.push_back(vec_t'{1, 0, 0, 0, 1,  16'h0000, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 1,  16'h0001, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 59, 16'h5901, 0, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 1,  16'h0001, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 0, 1,  16'h0000, 0, 0});

    do_reset();
    check("reset", 16'h0000, 0, 0);

    foreach (tbl[n]) begin
      for (int r = 0; r < tbl[n].reps; r++)
        cyc(tbl[n].s, tbl[n].c, tbl[n].i, tbl[n].sel);
      check($sformatf("vec%0d", n), tbl[n].d, tbl[n].st, tbl[n].ex);
    end

    // Expiry from 00:02
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    check("exp_start", 16'h0002, 1, 0);
    nops(4);
    check("exp_dec1", 16'h0001, 1, 0);
    nops(4);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("reload1", 16'h0002, 1, 1);
    nops(1);
    check("reload_pulse_end", 16'h0002, 1, 0);
    nops(7);
    check("reload2", 16'h0002, 1, 1);
    cyc(0, 1, 0, 0);
    check("reload_clear", 16'h0000, 0, 0);
`else
    check("exp_zero", 16'h0000, 3, 1);
    nops(1);
    check("exp_pulse_end", 16'h0000, 3, 0);
    cyc(1, 0, 0, 0);
    check("exp_to_idle", 16'h0000, 0, 0);
`endif

    // Start coincident with a tick pauses and drops the tick
    for (int j = 0; j < 10; j++) cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    nops(3);
    cyc(1, 0, 0, 0);
    check("pause_on_tick", 16'h0010, 2, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check("pause_inc", 16'h0012, 2, 0);
    cyc(1, 0, 0, 0);
    nops(3);
    check("resume_hold", 16'h0012, 1, 0);
    nops(1);
    check("resume_dec", 16'h0011, 1, 0);

    // clear beats start
    cyc(1, 1, 0, 0);
    check("clear_start", 16'h0000, 0, 0);

    // reset mid-count
    for (int j = 0; j < 3; j++) cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    nops(2);
    reset = 1; start = 1;
    @(posedge clk);
    #1;
    check("reset_mid", 16'h0000, 0, 0);
    reset = 0; start = 0;
    m_reset();

    // Random run against the reference model
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom % 12) == 0, ($urandom % 80) == 0,
          ($urandom % 3) == 0, int'($urandom % 2));
      check("rand", m_digits(), mst, mexp[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
